alu_share_arbiter: RTL

Shares one combinational ALU instance (alu, WIDTH-parameterised) between NUM_REQ core-side requesters in the multicore cluster. It runs round-robin arbitration and latches the winner's operands and decode fields into an issue register that drives the ALU. It then captures the ALU outputs into a response register and returns them to the winning requester over a valid/ready handshake. One transaction is in flight at a time.

---
 rtl/alu_arb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/alu_share_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU-sharing arbiter and its benches.
package alu_arb_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
  } alu_req_t;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [6:0] F7_ADD    = 7'b0000000;
  localparam logic [6:0] F7_SUB    = 7'b0100000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid index at or after ptr wins.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  always_comb begin
    logic            found;
    logic [ID_W-1:0] k;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[k]) begin
        gnt[k]  = 1'b1;
        gnt_idx = k;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU among NUM_REQ requesters; one transaction
// in flight: grant/latch (IDLE) -> ALU evaluate (EXEC) -> hold response (RESP).
module alu_share_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 32,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_op1,
  input  logic [NUM_REQ*WIDTH-1:0] req_op2,
  input  logic [NUM_REQ*7-1:0]     req_opcode,
  input  logic [NUM_REQ*3-1:0]     req_funct3,
  input  logic [NUM_REQ*7-1:0]     req_funct7,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_zero,
  output logic                     rsp_status,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         alu_op1,
  output logic [WIDTH-1:0]         alu_op2,
  output logic [6:0]               alu_opcode,
  output logic [2:0]               alu_funct3,
  output logic [6:0]               alu_funct7,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_zero,
  input  logic                     alu_status
);
  import alu_arb_pkg::*;

  typedef struct packed {
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
  } issue_t;

  // Flat request buses viewed as per-requester packed arrays (same bit layout).
  logic [NUM_REQ-1:0][WIDTH-1:0] op1_a, op2_a;
  logic [NUM_REQ-1:0][6:0]       opc_a, f7_a;
  logic [NUM_REQ-1:0][2:0]       f3_a;

  assign op1_a = req_op1;
  assign op2_a = req_op2;
  assign opc_a = req_opcode;
  assign f3_a  = req_funct3;
  assign f7_a  = req_funct7;

  arb_state_e          state;
  logic [ID_W-1:0]     ptr, owner, gidx, ptr_nxt;
  logic [NUM_REQ-1:0]  gnt;
  issue_t              issue;
  logic                hs, done;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gidx)
  );

  assign req_ready = (state == IDLE) ? gnt : '0;
  assign hs        = |(req_valid & req_ready);
  assign done      = (state == RESP) && rsp_ready[rsp_id];
  assign ptr_nxt   = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + ID_W'(1);

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[rsp_id] = 1'b1;
  end

  assign alu_op1    = issue.op1;
  assign alu_op2    = issue.op2;
  assign alu_opcode = issue.opcode;
  assign alu_funct3 = issue.funct3;
  assign alu_funct7 = issue.funct7;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      issue      <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_status <= 1'b0;
      rsp_id     <= '0;
    end else begin
      case (state)
        IDLE: if (hs) begin
          issue <= '{op1: op1_a[gidx], op2: op2_a[gidx], opcode: opc_a[gidx],
                     funct3: f3_a[gidx], funct7: f7_a[gidx]};
          owner <= gidx;
          ptr   <= ptr_nxt;
          state <= EXEC;
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_status <= alu_status;
          rsp_id     <= owner;
          state      <= RESP;
        end
        RESP: if (done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
